// File: rtl/cell_select_debounced.sv
// cell_select_debounced
//   Board-cell selector. A raw push button is synchronized, debounced and
//   turned into a single press event; at that event the cell index on pos_in
//   is either accepted (one-cycle one-hot strobe, cell marked occupied) or
//   rejected (cell already taken or index out of range).
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   pos_in      cell index, sampled at the press-evaluation edge
//   btn         raw asynchronous push button, active high
//   clear       synchronous board clear (pulse or level)
//   sel_onehot  one-hot selected cell, nonzero only with sel_valid
//   sel_valid   one-cycle accept strobe
//   sel_reject  one-cycle reject strobe
//   occupied    occupancy mask, bit i = cell i taken
//   board_full  all NUM_CELLS cells taken
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for debounced press; evaluates pos_in when it comes
//   WAIT_REL | press handled, waiting for debounced release

module cell_select_debounced #(
  parameter int NUM_CELLS       = 9,
  parameter int POS_W           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [POS_W-1:0]     pos_in,
  input  logic                 btn,
  input  logic                 clear,
  output logic [NUM_CELLS-1:0] sel_onehot,
  output logic                 sel_valid,
  output logic                 sel_reject,
  output logic [NUM_CELLS-1:0] occupied,
  output logic                 board_full
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_t;

  logic             btn_s1, btn_s2;
  logic             btn_stable;
  logic [CNT_W-1:0] count;

  state_t               state, state_nxt;
  logic [NUM_CELLS-1:0] sel_onehot_nxt;
  logic                 sel_valid_nxt, sel_reject_nxt;
  logic [NUM_CELLS-1:0] occupied_nxt;
  logic                 board_full_nxt;

  logic [NUM_CELLS-1:0] pos_mask;
  logic                 in_range;
  logic                 cell_taken;

  // Synchronizer and debouncer: btn_stable only follows btn_s2 after it has
  // disagreed for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_stable <= 1'b0;
      count      <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      if (btn_s2 != btn_stable) begin
        if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_stable <= btn_s2;
          count      <= '0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

  // Out-of-range indices shift the single bit off the end, leaving the mask
  // empty, so no occupied[] lookup with an oversized index is needed.
  assign pos_mask   = NUM_CELLS'(1) << pos_in;
  assign in_range   = ({1'b0, pos_in} < (POS_W + 1)'(NUM_CELLS));
  assign cell_taken = |(occupied & pos_mask);

  always_comb begin
    state_nxt      = state;
    sel_onehot_nxt = '0;
    sel_valid_nxt  = 1'b0;
    sel_reject_nxt = 1'b0;
    occupied_nxt   = occupied;

    case (state)
      IDLE: begin
        if (btn_stable) begin
          state_nxt = WAIT_REL;
          // A press coinciding with clear is dropped entirely.
          if (!clear) begin
            if (in_range && !cell_taken) begin
              sel_valid_nxt  = 1'b1;
              sel_onehot_nxt = pos_mask;
              occupied_nxt   = occupied | pos_mask;
            end else begin
              sel_reject_nxt = 1'b1;
            end
          end
        end
      end
      WAIT_REL: begin
        if (!btn_stable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (clear) occupied_nxt = '0;
    board_full_nxt = &occupied_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_onehot <= '0;
      sel_valid  <= 1'b0;
      sel_reject <= 1'b0;
      occupied   <= '0;
      board_full <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel_onehot <= sel_onehot_nxt;
      sel_valid  <= sel_valid_nxt;
      sel_reject <= sel_reject_nxt;
      occupied   <= occupied_nxt;
      board_full <= board_full_nxt;
    end
  end

endmodule

// File: tb/tb_cell_select_debounced.sv
module tb_cell_select_debounced;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pos_in;
  logic       btn;
  logic       clear;
  logic [8:0] sel_onehot;
  logic       sel_valid;
  logic       sel_reject;
  logic [8:0] occupied;
  logic       board_full;

  int checks   = 0;
  int failures = 0;

  int         valid_cnt = 0;
  int         rej_cnt   = 0;
  int         both_cnt  = 0;
  int         leak_cnt  = 0;
  logic [8:0] last_oh   = '0;

  int v0, r0;

  cell_select_debounced #(
    .NUM_CELLS(9), .POS_W(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .pos_in(pos_in), .btn(btn), .clear(clear),
    .sel_onehot(sel_onehot), .sel_valid(sel_valid), .sel_reject(sel_reject),
    .occupied(occupied), .board_full(board_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sel_valid) begin
      valid_cnt++;
      last_oh = sel_onehot;
    end
    if (sel_reject) rej_cnt++;
    if (sel_valid && sel_reject) both_cnt++;
    if (!sel_valid && sel_onehot != 9'h000) leak_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] p);
    pos_in = p;
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; clear = 1'b0; pos_in = 4'd0;
    repeat (2) tick();
    chk("rst_valid",    32'(sel_valid),  32'h0);
    chk("rst_reject",   32'(sel_reject), 32'h0);
    chk("rst_onehot",   32'(sel_onehot), 32'h0);
    chk("rst_occupied", 32'(occupied),   32'h000);
    chk("rst_full",     32'(board_full), 32'h0);
    rst = 1'b0;
    tick();

    // Accept on cell 4: strobe in the cycle after E7 only
    pos_in = 4'd4; btn = 1'b1;
    repeat (6) tick();
    chk("lat_before_e7", 32'(sel_valid), 32'h0);
    tick();
    chk("lat_valid_e7",  32'(sel_valid),  32'h1);
    chk("lat_onehot_e7", 32'(sel_onehot), 32'h010);
    chk("lat_occ_e7",    32'(occupied),   32'h010);
    tick();
    chk("lat_valid_e8",  32'(sel_valid),  32'h0);
    chk("lat_onehot_e8", 32'(sel_onehot), 32'h0);
    repeat (12) tick();
    chk("hold20_one_valid", 32'(valid_cnt), 32'd1);
    btn = 1'b0;
    repeat (10) tick();

    // Glitchy button 1,1,1,0 x5 is filtered
    v0 = valid_cnt; r0 = rej_cnt;
    pos_in = 4'd2;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; tick(); tick(); tick();
      btn = 1'b0; tick();
    end
    repeat (10) tick();
    chk("glitch_no_valid",  32'(valid_cnt - v0), 32'd0);
    chk("glitch_no_reject", 32'(rej_cnt - r0),   32'd0);
    chk("glitch_occ",       32'(occupied),       32'h010);

    // Rejects: taken cell, out-of-range indices
    v0 = valid_cnt; r0 = rej_cnt;
    press(4'd4);
    chk("rej_taken", 32'(rej_cnt - r0), 32'd1);
    press(4'd9);
    chk("rej_pos9", 32'(rej_cnt - r0), 32'd2);
    press(4'd15);
    chk("rej_pos15",    32'(rej_cnt - r0),   32'd3);
    chk("rej_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("rej_occ",      32'(occupied),       32'h010);

    // Fill the board
    v0 = valid_cnt;
    for (int c = 0; c < 8; c++) begin
      if (c != 4) press(4'(c));
    end
    chk("fill7_occ",  32'(occupied),   32'h0FF);
    chk("fill7_full", 32'(board_full), 32'h0);
    press(4'd8);
    chk("fill_strobes", 32'(valid_cnt - v0), 32'd8);
    chk("fill_last_oh", 32'(last_oh),        32'h100);
    chk("fill_occ",     32'(occupied),       32'h1FF);
    chk("fill_full",    32'(board_full),     32'h1);

    // Clear coincident with the press-evaluation edge
    v0 = valid_cnt; r0 = rej_cnt;
    pos_in = 4'd0; btn = 1'b1;
    repeat (6) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_occ",  32'(occupied),   32'h000);
    chk("clr_full", 32'(board_full), 32'h0);
    repeat (3) tick();
    btn = 1'b0;
    repeat (10) tick();
    chk("clr_no_valid",  32'(valid_cnt - v0), 32'd0);
    chk("clr_no_reject", 32'(rej_cnt - r0),   32'd0);

    // Held 50 cycles: exactly one event
    v0 = valid_cnt; r0 = rej_cnt;
    pos_in = 4'd0; btn = 1'b1;
    repeat (50) tick();
    chk("held_one_valid", 32'(valid_cnt - v0), 32'd1);
    chk("held_oh",        32'(last_oh),        32'h001);
    chk("held_no_reject", 32'(rej_cnt - r0),   32'd0);

    // Reset while held, then a fresh press after re-debounce
    rst = 1'b1;
    tick();
    chk("midrst_occ",   32'(occupied),   32'h000);
    chk("midrst_valid", 32'(sel_valid),  32'h0);
    chk("midrst_oh",    32'(sel_onehot), 32'h0);
    rst = 1'b0;
    v0 = valid_cnt;
    repeat (6) tick();
    chk("post_rst_early", 32'(valid_cnt - v0), 32'd0);
    repeat (14) tick();
    chk("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
    chk("post_rst_oh",    32'(last_oh),        32'h001);
    chk("post_rst_occ",   32'(occupied),       32'h001);
    btn = 1'b0;
    repeat (10) tick();

    chk("never_both_strobes", 32'(both_cnt), 32'd0);
    chk("onehot_only_valid",  32'(leak_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
